// File: rtl/debug_loader_ctrl.sv
// Byte-command debug/loader controller: loads instruction words into IMEM and runs or steps the pipeline.
// Build option: define DBG_TIMEOUT_EN to bound RUN with a MAX_RUN_CYCLES watchdog.

module debug_loader_ctrl #(
`ifdef DBG_TIMEOUT_EN
    parameter int                  MAX_RUN_CYCLES = 4096,
`endif
    parameter int                  NB_DATA   = 32,
    parameter int                  NB_IADDR  = 8,
    parameter logic [NB_DATA-1:0]  HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [7:0]          CMD_LOAD  = 8'h4C,
    parameter logic [7:0]          CMD_RUN   = 8'h52,
    parameter logic [7:0]          CMD_STEP  = 8'h53,
    parameter logic [7:0]          CMD_RST   = 8'h58
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_pipe_halted,
    output logic                o_we_IF,
    output logic [NB_DATA-1:0]  o_instruction_data,
    output logic [NB_IADDR-1:0] o_inst_addr,
    output logic                o_run_en,
    output logic                o_pipe_rst,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [2:0]          o_state
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_BCNT  = $clog2(NB_BYTES);
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_BYTE = 3'd1,
        S_LOAD_WR   = 3'd2,
        S_RUN       = 3'd3,
        S_STEP      = 3'd4,
        S_PRST      = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [NB_IADDR-1:0]   addr_q, addr_d;
    logic [NB_BCNT-1:0]    bcnt_q, bcnt_d;
    logic [NB_DATA-9:0]    acc_q, acc_d;
    logic                  we_q, we_d;
    logic [NB_DATA-1:0]    data_q, data_d;
    logic [NB_IADDR-1:0]   oaddr_q, oaddr_d;
    logic                  run_en_q, run_en_d;
    logic                  pipe_rst_q, pipe_rst_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
`ifdef DBG_TIMEOUT_EN
    localparam int NB_RCNT = $clog2(MAX_RUN_CYCLES + 1);
    logic [NB_RCNT-1:0]    run_cnt_q, run_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        bcnt_d     = bcnt_q;
        acc_d      = acc_q;
        we_d       = 1'b0;
        data_d     = data_q;
        oaddr_d    = oaddr_q;
        run_en_d   = 1'b0;
        pipe_rst_d = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
`ifdef DBG_TIMEOUT_EN
        run_cnt_d  = run_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            addr_d     = '0;
                            bcnt_d     = '0;
                            err_d      = 1'b0;
                            pipe_rst_d = 1'b1;
                            state_d    = S_LOAD_BYTE;
                        end
                        // Halt is sampled at decode so a halted pipeline never sees a stray advance.
                        CMD_RUN: begin
                            err_d    = 1'b0;
                            run_en_d = !i_pipe_halted;
`ifdef DBG_TIMEOUT_EN
                            run_cnt_d = '0;
`endif
                            state_d  = S_RUN;
                        end
                        CMD_STEP: begin
                            err_d    = 1'b0;
                            run_en_d = !i_pipe_halted;
                            state_d  = S_STEP;
                        end
                        CMD_RST: begin
                            pipe_rst_d = 1'b1;
                            state_d    = S_PRST;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD_BYTE: begin
                if (i_rx_valid) begin
                    acc_d  = {acc_q[NB_DATA-17:0], i_rx_data};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == LAST_BYTE) begin
                        bcnt_d  = '0;
                        we_d    = 1'b1;
                        data_d  = {acc_q, i_rx_data};
                        oaddr_d = addr_q;
                        state_d = S_LOAD_WR;
                    end
                end
            end
            S_LOAD_WR: begin
                addr_d = addr_q + 1'b1;
                if (data_q == HALT_WORD) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else if (addr_q == '1) begin
                    // Memory full: stop instead of wrapping onto address 0.
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_LOAD_BYTE;
                end
            end
            S_RUN: begin
                if (i_pipe_halted) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end
`ifdef DBG_TIMEOUT_EN
                else if (run_en_q && run_cnt_q == NB_RCNT'(MAX_RUN_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end
`endif
                else begin
                    run_en_d = 1'b1;
`ifdef DBG_TIMEOUT_EN
                    run_cnt_d = run_cnt_q + NB_RCNT'(run_en_q);
`endif
                end
            end
            S_STEP, S_PRST: begin
                done_d  = 1'b1;
                state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            bcnt_q     <= '0;
            we_q       <= 1'b0;
            data_q     <= '0;
            oaddr_q    <= '0;
            run_en_q   <= 1'b0;
            pipe_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef DBG_TIMEOUT_EN
            run_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            bcnt_q     <= bcnt_d;
            we_q       <= we_d;
            data_q     <= data_d;
            oaddr_q    <= oaddr_d;
            run_en_q   <= run_en_d;
            pipe_rst_q <= pipe_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef DBG_TIMEOUT_EN
            run_cnt_q  <= run_cnt_d;
`endif
        end
    end

    // Partial-word accumulator is fully overwritten before use, so it needs no reset.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign o_we_IF            = we_q;
    assign o_instruction_data = data_q;
    assign o_inst_addr        = oaddr_q;
    assign o_run_en           = run_en_q;
    assign o_pipe_rst         = pipe_rst_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_err              = err_q;
    assign o_state            = state_q;

endmodule

// File: tb/tb_debug_loader_ctrl.sv
// Scoreboard bench for debug_loader_ctrl: stimulus tasks queue expected events, a negedge monitor checks them.
module tb_debug_loader_ctrl;

    localparam int NB_IADDR = 2;
    localparam int DEPTH    = 1 << NB_IADDR;
    localparam int MAXC     = 16;
`ifdef DBG_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic                clk = 1'b0;
    logic                i_rst = 1'b1;
    logic [7:0]          rx_data = 8'h00;
    logic                rx_valid = 1'b0;
    logic                halted = 1'b0;
    logic                o_we_IF;
    logic [31:0]         o_instruction_data;
    logic [NB_IADDR-1:0] o_inst_addr;
    logic                o_run_en, o_pipe_rst, o_busy, o_done, o_err;
    logic [2:0]          o_state;

    always #5 clk = ~clk;

    debug_loader_ctrl #(
`ifdef DBG_TIMEOUT_EN
        .MAX_RUN_CYCLES(MAXC),
`endif
        .NB_DATA(32),
        .NB_IADDR(NB_IADDR)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_pipe_halted(halted), .o_we_IF(o_we_IF), .o_instruction_data(o_instruction_data),
        .o_inst_addr(o_inst_addr), .o_run_en(o_run_en), .o_pipe_rst(o_pipe_rst),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_state(o_state)
    );

    typedef enum int {EV_RUN, EV_ERRCLR, EV_PRST, EV_WR, EV_ERRSET, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] ld_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          m_err = 1'b0;

    function automatic void expect_ev(ev_kind_t k, logic [31:0] a = 0, logic [31:0] b = 0);
        ev_t e;
        e.kind = k; e.a = a; e.b = b;
        exp_q.push_back(e);
    endfunction

    function automatic void observe(ev_kind_t k, logic [31:0] a, logic [31:0] b);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got %s a=%0h b=%0h, required none", k.name(), a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b) begin
                failures++;
                $display("FAIL event got %s a=%0h b=%0h, required %s a=%0h b=%0h",
                         k.name(), a, b, e.kind.name(), e.a, e.b);
            end
        end
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got %0h, required %0h", name, act, req);
        end
    endfunction

    // Monitor: turns DUT outputs into events, in a fixed per-cycle order.
    logic prev_run = 1'b0, prev_err = 1'b0;
    int   run_cnt = 0;
    always @(negedge clk) begin
        if (i_rst) begin
            prev_run <= 1'b0;
            prev_err <= 1'b0;
            run_cnt  <= 0;
        end else begin
            chk("we_and_run_exclusive", {31'd0, o_we_IF && o_run_en}, 32'd0);
            if (prev_run && !o_run_en) observe(EV_RUN, run_cnt, 0);
            if (o_run_en) run_cnt <= prev_run ? run_cnt + 1 : 1;
            if (prev_err && !o_err) observe(EV_ERRCLR, 0, 0);
            if (o_pipe_rst) observe(EV_PRST, 0, 0);
            if (o_we_IF) observe(EV_WR, 32'(o_inst_addr), o_instruction_data);
            if (!prev_err && o_err) observe(EV_ERRSET, 0, 0);
            if (o_done) observe(EV_DONE, 0, 0);
            prev_run <= o_run_en;
            prev_err <= o_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input int budget, input int run_target, input string tag);
        bit seen = 1'b0;
        int cnt = 0;
        for (int i = 0; i < budget; i++) begin
            if (o_run_en) begin
                cnt++;
                if (cnt == run_target) halted = 1'b1;
            end
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_done_timeout got no o_done in %0d cycles, required a pulse", tag, budget);
        end
        tick();
        chk({tag, "_busy_after"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_state_after"}, {29'd0, o_state}, 32'd0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    // Model of a load: words go to consecutive addresses until HALT or the last address.
    task automatic do_load();
        logic [31:0] sent[$];
        if (m_err) expect_ev(EV_ERRCLR);
        m_err = 1'b0;
        expect_ev(EV_PRST);
        for (int i = 0; i < ld_q.size(); i++) begin
            sent.push_back(ld_q[i]);
            expect_ev(EV_WR, i, ld_q[i]);
            if (ld_q[i] == HALT) break;
            if (i == DEPTH - 1) begin
                expect_ev(EV_ERRSET);
                m_err = 1'b1;
                break;
            end
        end
        expect_ev(EV_DONE);
        send_byte(8'h4C);
        foreach (sent[i]) begin
            for (int b = 3; b >= 0; b--) begin
                gap();
                send_byte(sent[i][8*b +: 8]);
            end
            tick();
        end
        wait_done(20, -1, "load");
    endtask

    task automatic load_random(input bit overflow);
        int n;
        ld_q.delete();
        n = overflow ? DEPTH : $urandom_range(1, DEPTH);
        for (int i = 0; i < n; i++)
            ld_q.push_back((!overflow && i == n - 1) ? HALT : rand_word());
        do_load();
    endtask

    task automatic do_run(input int n);
        if (m_err) expect_ev(EV_ERRCLR);
        m_err = 1'b0;
        if (n == 0) begin
            halted = 1'b1;
        end else if (TO_EN && n > MAXC) begin
            expect_ev(EV_RUN, MAXC);
            expect_ev(EV_ERRSET);
            m_err = 1'b1;
        end else begin
            expect_ev(EV_RUN, n);
        end
        expect_ev(EV_DONE);
        send_byte(8'h52);
        wait_done(100, n, "run");
        halted = 1'b0;
    endtask

    task automatic do_step(input bit h);
        if (m_err) expect_ev(EV_ERRCLR);
        m_err = 1'b0;
        if (!h) expect_ev(EV_RUN, 1);
        expect_ev(EV_DONE);
        halted = h;
        send_byte(8'h53);
        wait_done(20, -1, "step");
        halted = 1'b0;
    endtask

    task automatic do_prst();
        expect_ev(EV_PRST);
        expect_ev(EV_DONE);
        send_byte(8'h58);
        wait_done(20, -1, "prst");
    endtask

    task automatic bad_byte(input logic [7:0] b);
        if (!m_err) expect_ev(EV_ERRSET);
        m_err = 1'b1;
        send_byte(b);
        tick();
        tick();
        chk("bad_byte_busy", {31'd0, o_busy}, 32'd0);
        chk("bad_byte_err", {31'd0, o_err}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, {31'd0, o_we_IF}, 32'd0);
        chk({tag, "_data"}, o_instruction_data, 32'd0);
        chk({tag, "_addr"}, 32'(o_inst_addr), 32'd0);
        chk({tag, "_run_en"}, {31'd0, o_run_en}, 32'd0);
        chk({tag, "_pipe_rst"}, {31'd0, o_pipe_rst}, 32'd0);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
        chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
        chk({tag, "_state"}, {29'd0, o_state}, 32'd0);
    endtask

    task automatic mid_load_reset();
        if (m_err) expect_ev(EV_ERRCLR);
        m_err = 1'b0;
        expect_ev(EV_PRST);
        send_byte(8'h4C);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        #2;
        i_rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        tick();
        i_rst = 1'b0;
        chk("reset_pending_events", exp_q.size(), 0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int op;
        logic [7:0] b;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        i_rst = 1'b0;
        tick();

        ld_q = '{32'h2001_0014, HALT};
        do_load();
        do_run(12);
        repeat (3) do_step(1'b0);
        do_step(1'b1);
        load_random(1'b1);
        bad_byte(8'h7A);
        do_run($urandom_range(1, 20));
        mid_load_reset();
        do_prst();
        do_run(0);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 6);
            case (op)
                0: load_random(1'b0);
                1: load_random(1'b1);
                2: do_run($urandom_range(1, 20));
                3: do_run(0);
                4: do_step(1'($urandom_range(0, 1)));
                5: do_prst();
                default: begin
                    do b = 8'($urandom);
                    while (b == 8'h4C || b == 8'h52 || b == 8'h53 || b == 8'h58);
                    bad_byte(b);
                end
            endcase
        end
        do_run(20);

        repeat (5) tick();
        chk("final_pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
